// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, issues one imem request at a time and
// presents instructions to IF/ID. Optional misaligned-redirect trap: FETCH_MISALIGN_CHK_EN.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush_if_id,
  output logic        misalign_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, KILL, FAULT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_fault;
  logic        r_pend;

  logic        w_consume;
  logic        w_req_fire;
  logic        w_misalign;
  logic        w_out_after;
  logic [31:0] w_redir_pc;

  assign w_consume  = r_if_valid && !stall;
  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_redir_pc = redirect_target & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // A request is still owed a response after this edge unless it returns now.
  always_comb begin
    w_out_after = 1'b0;
    case (r_state)
      REQ:     w_out_after = w_req_fire;
      WAIT:    w_out_after = !imem_rsp_valid;
      KILL:    w_out_after = !imem_rsp_valid;
      FAULT:   w_out_after = r_pend && !imem_rsp_valid;
      default: w_out_after = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
      r_fault    <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      if (w_consume) r_if_valid <= 1'b0;
      if (r_state == IDLE) begin
        r_state <= REQ;
      end else if (redirect_valid) begin
        r_if_valid <= 1'b0;
        if (w_misalign) begin
          r_fault <= 1'b1;
          r_pend  <= w_out_after;
          r_state <= FAULT;
        end else begin
          r_fault <= 1'b0;
          r_pend  <= 1'b0;
          r_pc    <= w_redir_pc;
          r_state <= w_out_after ? KILL : REQ;
        end
      end else begin
        case (r_state)
          REQ: begin
            if (w_req_fire) begin
              r_req_pc <= r_pc;
              r_pc     <= r_pc + 32'd4;
              r_state  <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_req_pc;
              r_if_instr <= imem_rsp_data;
              r_state    <= REQ;
            end
          end
          KILL: begin
            if (imem_rsp_valid) r_state <= REQ;
          end
          FAULT: begin
            if (imem_rsp_valid) r_pend <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Requests are held back while the output entry is full and not draining.
  assign imem_req_valid = (r_state == REQ) && (!r_if_valid || !stall);
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;
  assign flush_if_id    = redirect_valid;
  assign misalign_fault = r_fault;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized self-checking bench for fetch_pc_gen, driven against a
// transaction-level model (outstanding-request queue with stale marking).
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush_if_id;
  logic        misalign_fault;

  fetch_pc_gen #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .flush_if_id    (flush_if_id),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } tx_t;

  tx_t         outq[$];
  bit          started;
  bit          mFault;
  bit          eValid;
  logic [31:0] mPc;
  logic [31:0] ePc;
  logic [31:0] eInstr;
  int          memWait;
  int          latSel;
  bit          spurOn;
  int          checks;
  int          errors;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    outq.delete();
    started = 0;
    mFault  = 0;
    eValid  = 0;
    ePc     = 32'h0;
    eInstr  = 32'h0;
    mPc     = 32'h0000_0100;
    memWait = 0;
  endtask

  // One clock: drive at the falling edge, check after settling, advance model.
  task automatic applyStimulus(input logic stallI, input logic readyI,
                               input logic redirI, input logic [31:0] tgtI);
    int  preSize;
    bit  expValid, fire, rspHit, misal;
    tx_t t;
    stall           = stallI;
    imem_req_ready  = readyI;
    redirect_valid  = redirI;
    redirect_target = tgtI;
    preSize = outq.size();
    if (preSize > 0 && memWait == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memData(outq[0].addr);
    end else if (preSize == 0 && spurOn && $urandom_range(9) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    expValid = started && !mFault && (preSize == 0) && (!eValid || !stallI);
    checkOutput("if_valid", {31'b0, if_valid}, {31'b0, eValid});
    if (eValid) begin
      checkOutput("if_pc", if_pc, ePc);
      checkOutput("if_instr", if_instr, eInstr);
    end
    checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, expValid});
    if (expValid) checkOutput("req_addr", imem_req_addr, mPc);
    checkOutput("flush", {31'b0, flush_if_id}, {31'b0, redirI});
    checkOutput("misalign", {31'b0, misalign_fault}, {31'b0, mFault});

    fire   = expValid && readyI;
    rspHit = imem_rsp_valid && (preSize > 0);
`ifdef FETCH_MISALIGN_CHK_EN
    misal = (tgtI[1:0] != 2'b00);
`else
    misal = 0;
`endif
    if (!started) begin
      started = 1;
    end else if (redirI) begin
      eValid = 0;
      foreach (outq[i]) outq[i].stale = 1;
      if (rspHit) void'(outq.pop_front());
      if (fire) outq.push_back('{mPc, 1'b1});
      if (misal) mFault = 1;
      else begin
        mFault = 0;
        mPc    = {tgtI[31:2], 2'b00};
      end
    end else begin
      if (eValid && !stallI) eValid = 0;
      if (rspHit) begin
        t = outq.pop_front();
        if (!t.stale) begin
          eValid = 1;
          ePc    = t.addr;
          eInstr = imem_rsp_data;
        end
      end
      if (fire) begin
        outq.push_back('{mPc, 1'b0});
        mPc = mPc + 32'd4;
      end
    end
    if (fire) memWait = (latSel == 0) ? $urandom_range(3) : latSel - 1;
    else if (preSize > 0 && memWait > 0) memWait--;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    resetModel();
    #1;
    checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("rst_misalign", {31'b0, misalign_fault}, 32'h0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h0000_0100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] randTarget();
    case ($urandom_range(3))
      0:       return $urandom & 32'hFFFF_FFFC;
      1:       return 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
      2:       return $urandom;
      default: return 32'h0000_0100 + ($urandom_range(63) << 2);
    endcase
  endfunction

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    latSel = 1;
    spurOn = 0;
    rst_n  = 1'b0;
    @(negedge clk);
    doReset();

    // Streaming with a 1-cycle memory from RESET_PC.
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Backpressure: hold a full output entry for 5 cycles, then release.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (eValid) found = 1;
      else applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("reach_full", {31'b0, found}, 32'h1);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect while waiting on a 3-cycle response.
    latSel = 3;
    found  = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (outq.size() > 0 && !outq[0].stale && memWait == 2) found = 1;
      else applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("reach_wait", {31'b0, found}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_2000);
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect in the same cycle as the response.
    latSel = 2;
    found  = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (outq.size() > 0 && !outq[0].stale && memWait == 0) found = 1;
      else applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("reach_rsp", {31'b0, found}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3000);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Address wrap past 0xFFFF_FFFC.
    latSel = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect, then an aligned one.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_2002);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3000);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic with a mid-run reset.
    latSel = 0;
    spurOn = 1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1500; i++) begin
        applyStimulus(($urandom_range(2) == 0), ($urandom_range(2) != 0),
                      ($urandom_range(11) == 0), randTarget());
      end
      if (pass == 0) doReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
